// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scan-out controller: register map, bit indices,
// pixel layout and the DAC conduit word packing.
package vga_pkg;

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_COLOR     = 3'd1;
  localparam logic [2:0] ADDR_POS       = 3'd2;
  localparam logic [2:0] ADDR_BUF_REQ   = 3'd3;
  localparam logic [2:0] ADDR_STATUS    = 3'd4;
  localparam logic [2:0] ADDR_FRAME_CNT = 3'd5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_SRC    = 2;

  localparam int STAT_VBLANK = 0;
  localparam int STAT_SWAP   = 1;
  localparam int STAT_IRQ    = 2;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_t;

  function automatic logic [31:0] pack_export(pixel_t p, logic hs, logic vs,
                                              logic blank_n, logic vga_clk);
    return {3'b000, vga_clk, 1'b0, blank_n, vs, hs, p};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-clock divider, h/v scan counters and registered sync/blank decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       active,
  output logic       vblank,
  output logic       vblank_evt,
  output logic       vga_clk,
  output logic       hs,
  output logic       vs,
  output logic       blank_n
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int TW = $clog2(CLK_DIV);

  localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_LAST = VW'(V_ACTIVE - 1);

  logic [TW-1:0] tcnt;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          tick, h_last, v_last;
  logic          h_act, v_act, h_sync, v_sync;

  assign tick   = en && (tcnt == T_LAST);
  assign h_last = (hcnt == H_LAST);
  assign v_last = (vcnt == V_LAST);

  // Disable acts like a soft reset so re-enabling always restarts at (0,0).
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      tcnt <= '0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      tcnt <= tick ? '0 : tcnt + 1'b1;
      if (tick) begin
        hcnt <= h_last ? '0 : hcnt + 1'b1;
        if (h_last) vcnt <= v_last ? '0 : vcnt + 1'b1;
      end
    end
  end

  assign h_act  = 32'(hcnt) < H_ACTIVE;
  assign v_act  = 32'(vcnt) < V_ACTIVE;
  assign h_sync = (32'(hcnt) >= H_ACTIVE + H_FP) && (32'(hcnt) < H_ACTIVE + H_FP + H_SYNC);
  assign v_sync = (32'(vcnt) >= V_ACTIVE + V_FP) && (32'(vcnt) < V_ACTIVE + V_FP + V_SYNC);

  assign active     = en && h_act && v_act;
  assign vblank     = 32'(vcnt) >= V_ACTIVE;
  assign vblank_evt = tick && h_last && (vcnt == V_VIS_LAST);
  assign vga_clk    = 32'(tcnt) >= CLK_DIV / 2;
  assign hpos       = 10'(hcnt);
  assign vpos       = 10'(vcnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs      <= 1'b1;
      vs      <= 1'b1;
      blank_n <= 1'b0;
    end else begin
      hs      <= !(en && h_sync);
      vs      <= !(en && v_sync);
      blank_n <= active;
    end
  end

endmodule

// File: rtl/avalon_vga_scanout_ctrl.sv
// Avalon-MM VGA scan-out: register file, double-buffer swap, frame IRQ and
// pixel source mux feeding the VGA DAC conduit.
module avalon_vga_scanout_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int COLOR_W  = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 AVL_READ,
  input  logic                 AVL_WRITE,
  input  logic                 AVL_CS,
  input  logic [3:0]           AVL_BYTE_EN,
  input  logic [2:0]           AVL_ADDR,
  input  logic [31:0]          AVL_WRITEDATA,
  output logic [31:0]          AVL_READDATA,
  input  logic [3*COLOR_W-1:0] PIX_IN,
  output logic [9:0]           FB_X,
  output logic [9:0]           FB_Y,
  output logic                 FB_SEL,
  output logic                 IRQ,
  output logic [31:0]          EXPORT_DATA
);

  logic [2:0]  ctrl;
  logic [23:0] color_reg;
  logic        buf_req, swap_pending, fb_sel, irq_flag, irq_q;
  logic [31:0] frame_cnt, rd_mux, rdata;
  pixel_t      pix_q;

  logic [9:0] xpos, ypos;
  logic       active, vblank, vblank_evt, vga_clk, hs, vs, blank_n;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV)
  ) u_timing (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .en        (ctrl[CTRL_EN]),
    .hpos      (xpos),
    .vpos      (ypos),
    .active    (active),
    .vblank    (vblank),
    .vblank_evt(vblank_evt),
    .vga_clk   (vga_clk),
    .hs        (hs),
    .vs        (vs),
    .blank_n   (blank_n)
  );

  logic wr, rd, wr_ctrl, wr_color, wr_buf, wr_stat;
  assign wr       = AVL_WRITE && AVL_CS;
  assign rd       = AVL_READ && AVL_CS;
  assign wr_ctrl  = wr && (AVL_ADDR == ADDR_CTRL);
  assign wr_color = wr && (AVL_ADDR == ADDR_COLOR);
  assign wr_buf   = wr && (AVL_ADDR == ADDR_BUF_REQ);
  assign wr_stat  = wr && (AVL_ADDR == ADDR_STATUS);

  logic unused_wr_bits;
  assign unused_wr_bits = ^{AVL_WRITEDATA[31:24], AVL_BYTE_EN[3]};

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ctrl      <= '0;
      color_reg <= '0;
      buf_req   <= 1'b0;
    end else begin
      if (wr_ctrl && AVL_BYTE_EN[0]) ctrl <= AVL_WRITEDATA[2:0];
      for (int i = 0; i < 3; i++)
        if (wr_color && AVL_BYTE_EN[i]) color_reg[8*i +: 8] <= AVL_WRITEDATA[8*i +: 8];
      if (wr_buf && AVL_BYTE_EN[0]) buf_req <= AVL_WRITEDATA[0];
    end
  end

  // The vblank event sees the pre-write buf_req/swap_pending, so a BUF_REQ
  // write on that cycle re-arms pending for the next frame instead of swapping.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      swap_pending <= 1'b0;
      fb_sel       <= 1'b0;
      irq_flag     <= 1'b0;
      irq_q        <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      if (wr_buf)          swap_pending <= 1'b1;
      else if (vblank_evt) swap_pending <= 1'b0;
      if (vblank_evt && swap_pending) fb_sel <= buf_req;
      if (vblank_evt)
        irq_flag <= 1'b1;
      else if (wr_stat && AVL_BYTE_EN[0] && AVL_WRITEDATA[STAT_IRQ])
        irq_flag <= 1'b0;
      if (vblank_evt) frame_cnt <= frame_cnt + 32'd1;
      irq_q <= irq_flag && ctrl[CTRL_IRQ_EN];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (AVL_ADDR)
      ADDR_CTRL:      rd_mux = {29'd0, ctrl};
      ADDR_COLOR:     rd_mux = {8'd0, color_reg};
      ADDR_POS:       rd_mux = {6'd0, ypos, 6'd0, xpos};
      ADDR_BUF_REQ:   rd_mux = {31'd0, buf_req};
      ADDR_STATUS:    rd_mux = {29'd0, irq_flag, swap_pending, vblank};
      ADDR_FRAME_CNT: rd_mux = frame_cnt;
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) rdata <= '0;
    else          rdata <= rd ? rd_mux : '0;
  end

  // Channels are MSB-aligned into 8-bit DAC fields; bits below COLOR_W read 0.
  logic [23:0] pix_fb, pix_col, pix_sel;
  for (genvar c = 0; c < 3; c++) begin : g_chan
    assign pix_fb[8*c +: 8]  = 8'(PIX_IN[COLOR_W*c +: COLOR_W]) << (8 - COLOR_W);
    assign pix_col[8*c +: 8] = color_reg[8*c +: 8] & (8'hFF << (8 - COLOR_W));
  end
  assign pix_sel = ctrl[CTRL_SRC] ? pix_fb : pix_col;

  always_ff @(posedge CLK) begin
    if (!RESET_N) pix_q <= '0;
    else          pix_q <= active ? pix_sel : '0;
  end

  assign AVL_READDATA = rdata;
  assign FB_X         = xpos;
  assign FB_Y         = ypos;
  assign FB_SEL       = fb_sel;
  assign IRQ          = irq_q;
  assign EXPORT_DATA  = pack_export(pix_q, hs, vs, blank_n, vga_clk);

endmodule

// File: tb/tb_avalon_vga_scanout_ctrl.sv
// Randomized self-checking bench; expected scan state is derived arithmetically
// from the number of clock edges since the controller was enabled.
module tb_avalon_vga_scanout_ctrl;

  localparam int H_A = 8, H_F = 2, H_S = 2, H_B = 2;
  localparam int V_A = 4, V_F = 1, V_S = 1, V_B = 1;
  localparam int D   = 2;
  localparam int HT  = H_A + H_F + H_S + H_B;
  localparam int VT  = V_A + V_F + V_S + V_B;
  localparam int E0  = D * HT * V_A;
  localparam int FRM = D * HT * VT;
  localparam logic [31:0] IDLE_EXPORT = 32'h0300_0000;

  localparam logic [2:0] A_CTRL = 3'd0, A_COLOR = 3'd1, A_POS = 3'd2, A_BUF = 3'd3;
  localparam logic [2:0] A_STAT = 3'd4, A_FCNT = 3'd5;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        AVL_READ = 1'b0, AVL_WRITE = 1'b0, AVL_CS = 1'b0;
  logic [3:0]  AVL_BYTE_EN = 4'h0;
  logic [2:0]  AVL_ADDR = 3'd0;
  logic [31:0] AVL_WRITEDATA = 32'd0;
  logic [31:0] AVL_READDATA;
  logic [23:0] PIX_IN;
  logic [9:0]  FB_X, FB_Y;
  logic        FB_SEL, IRQ;
  logic [31:0] EXPORT_DATA;

  int cyc = 0;
  int base = 0;
  int seed = 0;
  int errors = 0;
  int checks = 0;

  avalon_vga_scanout_ctrl #(
    .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
    .CLK_DIV(D), .COLOR_W(8)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .PIX_IN(PIX_IN),
    .FB_X(FB_X), .FB_Y(FB_Y), .FB_SEL(FB_SEL), .IRQ(IRQ), .EXPORT_DATA(EXPORT_DATA)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Synthetic framebuffer content as a function of scan position.
  function automatic logic [23:0] pixf(int x, int y, int s);
    return {8'(x * 29 + s), 8'((y * 53) ^ s), 8'(x + y * 7 + s)};
  endfunction
  assign PIX_IN = pixf(int'(FB_X), int'(FB_Y), seed);

  function automatic int hm(int n); return (n / D) % HT; endfunction
  function automatic int vm(int n); return (n / (D * HT)) % VT; endfunction
  function automatic int frames(int n); return (n < E0) ? 0 : (n - E0) / FRM + 1; endfunction

  function automatic logic [31:0] exp_export(int n, bit src, logic [23:0] col);
    int hp, vp;
    logic hs, vs, act;
    logic [23:0] rgb;
    if (n == 0) return IDLE_EXPORT;
    hp  = hm(n - 1);
    vp  = vm(n - 1);
    hs  = !(hp >= H_A + H_F && hp < H_A + H_F + H_S);
    vs  = !(vp >= V_A + V_F && vp < V_A + V_F + V_S);
    act = (hp < H_A) && (vp < V_A);
    rgb = !act ? 24'h0 : (src ? pixf(hp, vp, seed) : col);
    return {3'b000, ((n % D) >= D / 2), 1'b0, act, vs, hs, rgb};
  endfunction

  function automatic logic [31:0] exp_status(int n, bit irq, bit pend);
    return {29'd0, irq, pend, (vm(n) >= V_A)};
  endfunction

  task automatic step(); @(negedge CLK); endtask

  task automatic wait_n(int t);
    while (cyc - base < t) @(negedge CLK);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    AVL_WRITE = 1'b1; AVL_CS = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    @(negedge CLK);
    AVL_WRITE = 1'b0; AVL_CS = 1'b0; AVL_BYTE_EN = 4'h0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    AVL_READ = 1'b1; AVL_CS = 1'b1; AVL_ADDR = a;
    @(negedge CLK);
    AVL_READ = 1'b0; AVL_CS = 1'b0;
    d = AVL_READDATA;
  endtask

  task automatic enable(input logic [31:0] c);
    wr(A_CTRL, c, 4'hF);
    base = cyc;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_CS = 1'b0; AVL_BYTE_EN = 4'h0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of the conduit, scan coordinates and random POS reads.
  task automatic scan(int cycles, bit src, logic [23:0] col);
    bit pend;
    int n;
    logic [31:0] e, rexp;
    pend = 1'b0; rexp = '0;
    for (int k = 0; k < cycles; k++) begin
      n = cyc - base;
      e = exp_export(n, src, col);
      checks++;
      if (EXPORT_DATA !== e || FB_X !== 10'(hm(n)) || FB_Y !== 10'(vm(n))) begin
        errors++;
        $display("FAIL scan n=%0d: export=%h x=%0d y=%0d expected export=%h x=%0d y=%0d",
                 n, EXPORT_DATA, FB_X, FB_Y, e, hm(n), vm(n));
      end
      checks++;
      if (AVL_READDATA !== (pend ? rexp : 32'd0)) begin
        errors++;
        $display("FAIL pos_read n=%0d: got %h expected %h", n, AVL_READDATA, pend ? rexp : 32'd0);
      end
      pend = ($urandom_range(0, 5) == 0);
      rexp = {6'd0, 10'(vm(n)), 6'd0, 10'(hm(n))};
      AVL_READ = pend; AVL_CS = pend; AVL_ADDR = A_POS;
      @(negedge CLK);
    end
    AVL_READ = 1'b0; AVL_CS = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    chk("reset_export", EXPORT_DATA, IDLE_EXPORT);
    chk("reset_fb", {FB_SEL, IRQ, FB_X, FB_Y}, '0);
    chk("reset_rdata", AVL_READDATA, 32'd0);
    repeat (50) step();
    chk("idle_export", EXPORT_DATA, IDLE_EXPORT);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      chk($sformatf("reset_reg%0d", a), d, 32'd0);
    end
  endtask

  task automatic test_timing();
    logic [23:0] col;
    bit src;
    do_reset();
    col = 24'hFF8040;
    wr(A_COLOR, 32'h00FF8040, 4'hF);
    enable(32'h1);
    scan(FRM + 40, 1'b0, col);
    for (int it = 0; it < 4; it++) begin
      wr(A_CTRL, 32'h0, 4'hF);
      step();
      chk("disabled_export", EXPORT_DATA, IDLE_EXPORT);
      chk("disabled_pos", {FB_X, FB_Y}, '0);
      col = 24'($urandom);
      src = it[0];
      seed = int'($urandom_range(0, 255));
      wr(A_COLOR, {8'($urandom), col}, 4'hF);
      enable(src ? 32'h5 : 32'h1);
      scan(int'($urandom_range(60, FRM + 30)), src, col);
    end
  endtask

  task automatic test_swap();
    logic [31:0] d;
    int n;
    do_reset();
    enable(32'h1);
    repeat ($urandom_range(10, 80)) step();
    wr(A_BUF, 32'h1, 4'hF);
    n = cyc - base;
    rd(A_STAT, d);
    chk("swap_pending_status", d, exp_status(n, 1'b0, 1'b1));
    wait_n(E0 - 1);
    chk("fb_sel_before_vblank", {31'd0, FB_SEL}, 32'd0);
    step();
    chk("fb_sel_after_vblank", {31'd0, FB_SEL}, 32'd1);
    chk("irq_masked", {31'd0, IRQ}, 32'd0);
    n = cyc - base;
    rd(A_STAT, d);
    chk("status_after_swap", d, exp_status(n, 1'b1, 1'b0));
    n = cyc - base;
    rd(A_FCNT, d);
    chk("frame_cnt", d, 32'(frames(n)));
  endtask

  task automatic test_irq();
    logic [31:0] d;
    int n;
    do_reset();
    enable(32'h3);
    wait_n(E0);
    chk("irq_latency", {31'd0, IRQ}, 32'd0);
    step();
    chk("irq_rise", {31'd0, IRQ}, 32'd1);
    repeat ($urandom_range(1, 20)) step();
    wr(A_STAT, 32'h4, 4'h1);
    chk("irq_hold_w1c_edge", {31'd0, IRQ}, 32'd1);
    step();
    chk("irq_cleared", {31'd0, IRQ}, 32'd0);
    n = cyc - base;
    rd(A_STAT, d);
    chk("status_cleared", d, exp_status(n, 1'b0, 1'b0));
    wait_n(E0 + FRM - 1);
    wr(A_STAT, 32'h4, 4'h1);
    step();
    chk("irq_set_wins", {31'd0, IRQ}, 32'd1);
    n = cyc - base;
    rd(A_STAT, d);
    chk("status_set_wins", d, exp_status(n, 1'b1, 1'b0));
    n = cyc - base;
    rd(A_FCNT, d);
    chk("frame_cnt2", d, 32'(frames(n)));
  endtask

  task automatic test_swap_conflict();
    logic [31:0] d;
    int n;
    do_reset();
    enable(32'h1);
    wait_n(E0 - 1);
    wr(A_BUF, 32'h1, 4'hF);
    chk("conflict_no_swap", {31'd0, FB_SEL}, 32'd0);
    n = cyc - base;
    rd(A_STAT, d);
    chk("conflict_pending", d, exp_status(n, 1'b1, 1'b1));
    wait_n(E0 + FRM - 1);
    chk("conflict_before_next", {31'd0, FB_SEL}, 32'd0);
    step();
    chk("conflict_swapped", {31'd0, FB_SEL}, 32'd1);
  endtask

  task automatic test_byte_en();
    logic [31:0] d, wd;
    logic [23:0] col_m;
    logic [3:0] be;
    do_reset();
    wr(A_COLOR, 32'hAAAA_AAAA, 4'b0010);
    rd(A_COLOR, d);
    chk("color_be_0010", d, 32'h0000_AA00);
    col_m = 24'h00AA00;
    for (int i = 0; i < 6; i++) begin
      wd = $urandom;
      be = 4'($urandom);
      for (int b = 0; b < 3; b++) if (be[b]) col_m[8*b +: 8] = wd[8*b +: 8];
      wr(A_COLOR, wd, be);
      rd(A_COLOR, d);
      chk("color_rand_be", d, {8'd0, col_m});
    end
    wr(A_CTRL, 32'h7, 4'b1110);
    rd(A_CTRL, d);
    chk("ctrl_be_off", d, 32'd0);
    wr(A_CTRL, 32'hFFFF_FFF6, 4'h1);
    rd(A_CTRL, d);
    chk("ctrl_mask", d, 32'h6);
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_FCNT, $urandom, 4'hF);
    wr(3'd6, $urandom, 4'hF);
    wr(A_POS, $urandom, 4'hF);
    rd(A_FCNT, d);
    chk("fcnt_ro", d, 32'd0);
    rd(3'd6, d);
    chk("addr6_zero", d, 32'd0);
    rd(A_POS, d);
    chk("pos_ro", d, 32'd0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    do_reset();
    wr(A_COLOR, 32'h00123456, 4'hF);
    wr(A_BUF, 32'h1, 4'hF);
    enable(32'h3);
    wait_n(E0 + 2 + int'($urandom_range(0, 30)));
    chk("pre_reset_state", {30'd0, FB_SEL, IRQ}, 32'h3);
    RESET_N = 1'b0;
    step();
    chk("midreset_export", EXPORT_DATA, IDLE_EXPORT);
    chk("midreset_outs", {FB_SEL, IRQ, FB_X, FB_Y}, '0);
    chk("midreset_rdata", AVL_READDATA, 32'd0);
    RESET_N = 1'b1;
    for (int a = 0; a < 6; a++) begin
      rd(3'(a), d);
      chk($sformatf("post_reset_reg%0d", a), d, 32'd0);
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_timing();
    test_swap();
    test_irq();
    test_swap_conflict();
    test_byte_en();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_vga_scanout_ctrl.md
# avalon_vga_scanout_ctrl

Parametrised Avalon-MM VGA scan-out controller, the next generation of our Avalon VGA interface. It generates the programmable video timing on a divided pixel-clock enable and drives the VGA DAC conduit. Pixels come either from a solid-colour register or from a framebuffer pixel input. It double-buffers the framebuffer select, swaps buffers only at vertical-blank entry, and raises a frame interrupt.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal porches and sync width, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical porches and sync width, in lines.
- CLK_DIV, 2: CLK cycles per pixel; must be ≥2.
- COLOR_W, 8: bits per colour channel; must be ≤8.

Ports:
- CLK, in, 1: single clock.
- RESET_N, in, 1: synchronous, active-low reset.
- AVL_READ / AVL_WRITE / AVL_CS, in, 1 each: Avalon-MM slave controls.
- AVL_BYTE_EN, in, 4: write byte enables; honoured per byte.
- AVL_ADDR, in, 3: word address.
- AVL_WRITEDATA, in, 32: write data.
- AVL_READDATA, out, 32: read data, read latency 1.
- PIX_IN, in, 3*COLOR_W: framebuffer pixel {B,G,R} for the current FB_X/FB_Y.
- FB_X / FB_Y, out, 10 each: current scan coordinates (DrawX/DrawY).
- FB_SEL, out, 1: front buffer being displayed.
- IRQ, out, 1: level interrupt, equal to STATUS.irq AND CTRL.irq_en.
- EXPORT_DATA, out, 32: [7:0] R, [15:8] G, [23:16] B (each MSB-aligned, zero-filled below COLOR_W), [24] HS, [25] VS, [26] BLANK_N, [27] SYNC_N (tied 0), [28] VGA_CLK, [31:29] 0.

## Operation
Register map:
- 0 CTRL (rw): bit0 enable, bit1 irq_en, bit2 src (0 = COLOR register, 1 = PIX_IN).
- 1 COLOR (rw): {B,G,R} in 8-bit fields.
- 2 POS (ro): {6'b0, DrawY, 6'b0, DrawX}.
- 3 BUF_REQ (rw): bit0 requested back buffer; a write sets swap_pending.
- 4 STATUS: bit0 vblank (ro), bit1 swap_pending (ro), bit2 irq (write-1-to-clear).
- 5 FRAME_CNT (ro): 32-bit count of frames, wraps.
- 6–7: read 0; writes ignored.

Timing generator:
- A tick counter runs 0..CLK_DIV-1; the pixel tick is asserted when it equals CLK_DIV-1.
- VGA_CLK is high while the tick counter ≥ CLK_DIV/2.
- On each tick, hcnt increments and wraps at H_TOTAL-1. On hcnt wrap, vcnt increments and wraps at V_TOTAL-1. Counters are sized with $clog2.
- HS is low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). VS uses the same rule with the vertical parameters.
- BLANK_N is high only when hcnt < H_ACTIVE and vcnt < V_ACTIVE. RGB outputs are 0 while blanked.
- CTRL.enable=0: tick and counters are held at 0, HS/VS are high, BLANK_N=0, RGB=0. Re-enabling starts at (0,0).

Vblank event (the tick where vcnt goes V_ACTIVE-1 → V_ACTIVE with hcnt wrapping):
- FRAME_CNT increments.
- STATUS.irq is set.
- If swap_pending, FB_SEL takes BUF_REQ.bit0 and swap_pending clears.

Conflict and boundary rules:
- A BUF_REQ write in the same cycle as the vblank event is not applied in that event. It stays pending for the next frame.
- A STATUS W1C in the same cycle as an irq set leaves irq set (set wins).
- Writes to read-only fields are ignored.
- Byte lanes whose enable is 0 are left unchanged.

## Timing
- Reset values: CTRL=0, COLOR=0, BUF_REQ=0, STATUS=0, FRAME_CNT=0, counters=0, FB_SEL=0, IRQ=0, AVL_READDATA=0. EXPORT_DATA has HS=VS=1, BLANK_N=0, RGB=0, VGA_CLK=0.
- Reset taken mid-frame returns everything to the reset values on the next CLK edge.
- HS, VS, BLANK_N and RGB are registered one CLK after the counter update. PIX_IN is sampled in that same cycle.
- AVL_READDATA is valid exactly 1 CLK after AVL_READ && AVL_CS, and is 0 otherwise. POS reflects the counters at the read cycle.
- Register writes take effect on the CLK edge of the write. The IRQ level follows STATUS one cycle later.

## Structure
- Shared package vga_pkg:
  - register address constants;
  - CTRL and STATUS bit-index constants;
  - a typedef struct for the {B,G,R} pixel;
  - a function packing the EXPORT_DATA word.
- One sub-module, vga_timing_gen, covering the tick divider, hcnt/vcnt, and the HS/VS/BLANK_N/vblank-event decode. It is parametrised with the timing parameters. Register file, swap logic and pixel mux stay in the top module.

## Test plan
Small parameters for simulation: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, CLK_DIV=2.
- Reset with enable=0 → HS=VS=1, BLANK_N=0, EXPORT_DATA[23:0]=0, and a read of POS after 50 cycles returns 0.
- Write CTRL=1, COLOR=0x00FF8040 → each line has 8 pixels with R=0x40, G=0x80, B=0xFF; HS low for 2 ticks starting at hcnt=10; line period 28 CLK; VS low on vcnt=5.
- Write BUF_REQ=1 mid-frame → STATUS=0x2 until the vblank event; then FB_SEL=1, STATUS=0x5, and FRAME_CNT=1.
- With CTRL=0x3, IRQ rises at vblank; a W1C write to STATUS bit2 → IRQ=0 next cycle. W1C issued on the vblank-event cycle → IRQ stays 1.
- BUF_REQ write landing exactly on the vblank-event cycle → FB_SEL unchanged this frame and swaps at the following vblank.
- Write COLOR with AVL_BYTE_EN=4'b0010 and data 0xAAAAAAAA → COLOR=0x0000AA00 from 0; assert RESET_N=0 mid-line → all reset values on the next edge.
